// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: bundles the requester-side and fpu-side signals of the
// fpu arbiter.
//
// Handshake rules:
//   requests : req_valid[i] is held with req_operation/req_data_* stable
//              until the arbiter pulses req_ack[i] for one cycle.
//   fpu in   : fpu_input_rdy is held with fpu_operation/fpu_data_* stable
//              until the fpu returns fpu_input_ack (sampled on a clock edge).
//   fpu out  : the fpu holds fpu_output_rdy/fpu_result until the arbiter
//              pulses fpu_output_ack for one cycle.
//   response : resp_valid[g] is held with resp_result/resp_error stable
//              until requester g raises resp_ack[g]; other resp_ack bits
//              are ignored.
//
// Modports:
//   master : the environment (requesters and the fpu itself)
//   slave  : the arbiter
interface fpu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][3:0]       req_operation;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_b;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [WIDTH-1:0]              resp_result;
  logic                          resp_error;
  logic [NUM_REQ-1:0]            resp_ack;
  logic [3:0]                    fpu_operation;
  logic [WIDTH-1:0]              fpu_data_a;
  logic [WIDTH-1:0]              fpu_data_b;
  logic                          fpu_input_rdy;
  logic                          fpu_input_ack;
  logic                          fpu_output_rdy;
  logic                          fpu_output_ack;
  logic [WIDTH-1:0]              fpu_result;

  modport master (
    output req_valid, req_operation, req_data_a, req_data_b, resp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    input  req_ack, resp_valid, resp_result, resp_error,
           fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack
  );

  modport slave (
    input  req_valid, req_operation, req_data_a, req_data_b, resp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    output req_ack, resp_valid, resp_result, resp_error,
           fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between NUM_REQ requesters. A requester is
// granted round-robin, its operation/operands are latched, the fpu
// input/output handshake is sequenced, and the result is returned on the
// per-requester response channel. One operation is in flight at a time.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : fpu_arbiter_if.slave (requests, responses, fpu side)
//   busy         : arbiter is not idle
//   grant_id     : index of current/last grantee
//   fsm_state    : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Optional feature macro: FPU_ARB_TIMEOUT_EN
//   Defined   : a watchdog aborts an operation after TIMEOUT_CYCLES cycles in
//               ISSUE/WAIT and returns all-ones with resp_error set.
//   Undefined : no watchdog, resp_error is constant 0.
//
// All outputs come straight from registers.
module fpu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int GID_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  fpu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [GID_W-1:0] grant_id,
  output logic [1:0]       fsm_state
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fpu_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_n;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_n;
  logic [WIDTH-1:0]   resp_result_q, resp_result_n;
  logic [3:0]         fpu_op_q, fpu_op_n;
  logic [WIDTH-1:0]   fpu_a_q, fpu_a_n;
  logic [WIDTH-1:0]   fpu_b_q, fpu_b_n;
  logic               in_rdy_q, in_rdy_n;
  logic               out_ack_q, out_ack_n;
  logic               busy_q;
  logic [GID_W-1:0]   grant_q, grant_n;
  logic [GID_W-1:0]   last_q, last_n;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] cnt_q, cnt_n;
  logic            resp_error_q, resp_error_n;
  logic            timeout_hit;
  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin pick: first valid requester after last_q, wrapping around.
  logic             pick_found;
  logic [GID_W-1:0] pick_idx;
  int               idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && bus.req_valid[GID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = GID_W'(idx);
      end
    end
  end

  always_comb begin
    state_n       = state_q;
    req_ack_n     = '0;
    resp_valid_n  = resp_valid_q;
    resp_result_n = resp_result_q;
    fpu_op_n      = fpu_op_q;
    fpu_a_n       = fpu_a_q;
    fpu_b_n       = fpu_b_q;
    in_rdy_n      = in_rdy_q;
    out_ack_n     = 1'b0;
    grant_n       = grant_q;
    last_n        = last_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_n         = cnt_q;
    resp_error_n  = resp_error_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_n   = pick_idx;
          fpu_op_n  = bus.req_operation[pick_idx];
          fpu_a_n   = bus.req_data_a[pick_idx];
          fpu_b_n   = bus.req_data_b[pick_idx];
          req_ack_n = NUM_REQ'(1) << pick_idx;
          in_rdy_n  = 1'b1;
          state_n   = ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end

      ISSUE: begin
        if (bus.fpu_input_ack) begin
          // A same-cycle fpu_output_rdy is left for WAIT to capture.
          in_rdy_n = 1'b0;
          state_n  = WAIT;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          resp_result_n = '1;
          resp_error_n  = 1'b1;
          in_rdy_n      = 1'b0;
          out_ack_n     = 1'b1;
          resp_valid_n  = NUM_REQ'(1) << grant_q;
          state_n       = RESP;
        end
        cnt_n = cnt_q + 1'b1;
`endif
      end

      WAIT: begin
        if (bus.fpu_output_rdy) begin
          resp_result_n = bus.fpu_result;
          out_ack_n     = 1'b1;
          resp_valid_n  = NUM_REQ'(1) << grant_q;
          state_n       = RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          resp_result_n = '1;
          resp_error_n  = 1'b1;
          out_ack_n     = 1'b1;
          resp_valid_n  = NUM_REQ'(1) << grant_q;
          state_n       = RESP;
        end
        cnt_n = cnt_q + 1'b1;
`endif
      end

      RESP: begin
        if (bus.resp_ack[grant_q]) begin
          resp_valid_n = '0;
          last_n       = grant_q;
          state_n      = IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
          resp_error_n = 1'b0;
`endif
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ack_q     <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      fpu_op_q      <= 4'b0000;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      in_rdy_q      <= 1'b0;
      out_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      grant_q       <= '0;
      last_q        <= GID_W'(NUM_REQ - 1);
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      resp_error_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_n;
      req_ack_q     <= req_ack_n;
      resp_valid_q  <= resp_valid_n;
      resp_result_q <= resp_result_n;
      fpu_op_q      <= fpu_op_n;
      fpu_a_q       <= fpu_a_n;
      fpu_b_q       <= fpu_b_n;
      in_rdy_q      <= in_rdy_n;
      out_ack_q     <= out_ack_n;
      busy_q        <= (state_n != IDLE);
      grant_q       <= grant_n;
      last_q        <= last_n;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q         <= cnt_n;
      resp_error_q  <= resp_error_n;
`endif
    end
  end

  assign bus.req_ack        = req_ack_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_result    = resp_result_q;
  assign bus.fpu_operation  = fpu_op_q;
  assign bus.fpu_data_a     = fpu_a_q;
  assign bus.fpu_data_b     = fpu_b_q;
  assign bus.fpu_input_rdy  = in_rdy_q;
  assign bus.fpu_output_ack = out_ack_q;
`ifdef FPU_ARB_TIMEOUT_EN
  assign bus.resp_error     = resp_error_q;
`else
  assign bus.resp_error     = 1'b0;
`endif
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed bench for fpu_arbiter with a small fpu model,
// a requester driver and a response monitor/scoreboard.
module tb_fpu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int GID_W   = 2;
  localparam int EW      = 1 + GID_W + WIDTH;

  logic             clock;
  logic             reset;
  logic             busy;
  logic [GID_W-1:0] grant_id;
  logic [1:0]       fsm_state;

  fpu_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fpu_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GID_W(GID_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .busy(busy), .grant_id(grant_id), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] cur_op = 4'b0000;
  int resp_delay[NUM_REQ];
  int resp_count = 0;
  int ack_pulses = 0;
  int rstate = 0;
  int hold_cnt[NUM_REQ];

  // fpu model knobs
  int fpu_ack_delay = 2;
  int fpu_out_delay = 2;
  bit fpu_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- fpu model ----------------
  function automatic logic [WIDTH-1:0] fpu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    if (op == 4'b0000 && a == 32'h3F800000 && b == 32'h3C23D70A) return 32'h3F8147AE;
    if (op == 4'b0010 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (op == 4'b0011 && a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
    return 32'hDEADBEEF;
  endfunction

  initial begin
    int m_state;
    int m_cnt;
    logic [3:0] m_op;
    logic [WIDTH-1:0] m_a, m_b;
    m_state = 0; m_cnt = 0; m_op = '0; m_a = '0; m_b = '0;
    bus.fpu_input_ack = 1'b0;
    bus.fpu_output_rdy = 1'b0;
    bus.fpu_result = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_state = 0; m_cnt = 0;
        bus.fpu_input_ack = 1'b0;
        bus.fpu_output_rdy = 1'b0;
      end else begin
        case (m_state)
          0: if (bus.fpu_input_rdy) begin
            if (m_cnt >= fpu_ack_delay) begin
              bus.fpu_input_ack = 1'b1;
              m_op = bus.fpu_operation; m_a = bus.fpu_data_a; m_b = bus.fpu_data_b;
              m_cnt = 0;
              if (!fpu_stall && fpu_out_delay == 0) begin
                bus.fpu_output_rdy = 1'b1;
                bus.fpu_result = fpu_fn(m_op, m_a, m_b);
                m_state = 2;
              end else m_state = 1;
            end else m_cnt++;
          end
          1: begin
            bus.fpu_input_ack = 1'b0;
            if (!fpu_stall) begin
              m_cnt++;
              if (m_cnt >= fpu_out_delay) begin
                bus.fpu_output_rdy = 1'b1;
                bus.fpu_result = fpu_fn(m_op, m_a, m_b);
                m_state = 2;
                m_cnt = 0;
              end
            end
          end
          default: begin
            bus.fpu_input_ack = 1'b0;
            if (bus.fpu_output_ack) begin
              bus.fpu_output_rdy = 1'b0;
              m_state = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- requester driver ----------------
  task automatic issue(input logic [1:0] r, input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int holds);
    bus.req_operation[r] = op;
    bus.req_data_a[r] = a;
    bus.req_data_b[r] = b;
    hold_cnt[r] = holds;
    bus.req_valid[r] = 1'b1;
  endtask

  // Drops req_valid once each requester has been granted hold_cnt times.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_ack[i]) begin
            hold_cnt[i]--;
            if (hold_cnt[i] <= 0) bus.req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- monitor / responder ----------------
  initial begin
    int rcnt;
    logic [GID_W-1:0] g;
    logic [WIDTH-1:0] held;
    logic [EW-1:0] e;
    rcnt = 0; g = '0; held = '0; e = '0;
    bus.resp_ack = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rstate = 0;
        bus.resp_ack = '0;
      end else begin
        if (bus.fpu_output_ack) ack_pulses++;
        if (bus.fpu_input_rdy) check("fpu_operation", 64'(bus.fpu_operation), 64'(cur_op));
        if (bus.req_ack != '0) begin
          check("req_ack_onehot", 64'(bus.req_ack), 64'(4'b0001 << grant_id));
          check("input_rdy_at_grant", 64'(bus.fpu_input_rdy), 64'd1);
        end
        if (rstate == 2) begin
          bus.resp_ack = '0;
          check("resp_valid_cleared", 64'(bus.resp_valid), 64'd0);
          rstate = 0;
        end else begin
          if (rstate == 0 && bus.resp_valid != '0) begin
            resp_count++;
            g = grant_id;
            held = bus.resp_result;
            rcnt = 0;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL resp_unexpected: got %0h expected none", {bus.resp_error, grant_id, bus.resp_result});
            end else begin
              e = exp_q.pop_front();
              check("resp", 64'({bus.resp_error, grant_id, bus.resp_result}), 64'(e));
              check("resp_valid_onehot", 64'(bus.resp_valid), 64'(4'b0001 << e[EW-2 -: GID_W]));
            end
            rstate = 1;
          end
          if (rstate == 1) begin
            if (rcnt >= resp_delay[g]) begin
              bus.resp_ack = 4'b0001 << g;
              rstate = 2;
            end else begin
              rcnt++;
              check("held_result", 64'(bus.resp_result), 64'(held));
              check("held_valid", 64'(bus.resp_valid), 64'(4'b0001 << g));
              check("no_issue_while_resp", 64'(bus.fpu_input_rdy), 64'd0);
            end
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic reset_check();
    check("rst_req_ack", 64'(bus.req_ack), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_ctrl", 64'({bus.fpu_input_rdy, bus.fpu_output_ack, busy, bus.resp_error}), 64'd0);
    check("rst_resp_result", 64'(bus.resp_result), 64'd0);
    check("rst_fpu_data", 64'({bus.fpu_data_a, bus.fpu_data_b}), 64'd0);
    check("rst_fpu_op", 64'(bus.fpu_operation), 64'd0);
    check("rst_grant_state", 64'({grant_id, fsm_state}), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset_check();
    reset = 1'b0;
  endtask

  task automatic wait_resps(input int n, input int budget);
    int target;
    bit done;
    target = resp_count + n;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      if (resp_count >= target && rstate == 0 && fsm_state == 2'd0) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_resps_timeout: got %0d expected %0d", resp_count, target);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      if (fsm_state == s) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_state_timeout: got %0d expected %0d", fsm_state, s);
    end
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_operation = '0;
    bus.req_data_a = '0;
    bus.req_data_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_delay[i] = 0;
      hold_cnt[i] = 0;
    end
    repeat (3) @(negedge clock);
    reset_check();
    reset = 1'b0;
    @(negedge clock);

    // Round-robin: requester 0 held for two grants -> 0,1,2,3,0.
    cur_op = 4'b0010;
    for (int i = 0; i < 5; i++)
      exp_q.push_back({1'b0, 2'(i % 4), 32'h40800000});
    issue(2'd0, 4'b0010, 32'h40000000, 32'h40000000, 2);
    issue(2'd1, 4'b0010, 32'h40000000, 32'h40000000, 1);
    issue(2'd2, 4'b0010, 32'h40000000, 32'h40000000, 1);
    issue(2'd3, 4'b0010, 32'h40000000, 32'h40000000, 1);
    wait_resps(5, 200);
    check("rr_ack_pulses", 64'(ack_pulses), 64'd5);

    // Single request from requester 0: 1.0 + 0.01.
    cur_op = 4'b0000;
    exp_q.push_back({1'b0, 2'd0, 32'h3F8147AE});
    @(negedge clock);
    issue(2'd0, 4'b0000, 32'h3F800000, 32'h3C23D70A, 1);
    wait_resps(1, 60);
    check("single_ack_pulses", 64'(ack_pulses), 64'd6);

    // Back-pressure: requester 1 holds off resp_ack 10 cycles, 2 pending.
    cur_op = 4'b0010;
    resp_delay[1] = 10;
    exp_q.push_back({1'b0, 2'd1, 32'h40800000});
    exp_q.push_back({1'b0, 2'd2, 32'h40800000});
    @(negedge clock);
    issue(2'd1, 4'b0010, 32'h40000000, 32'h40000000, 1);
    wait_state(2'd1, 10);
    issue(2'd2, 4'b0010, 32'h40000000, 32'h40000000, 1);
    wait_resps(2, 100);
    resp_delay[1] = 0;

    // Reset while requester 3's operation sits in WAIT; result is dropped.
    cur_op = 4'b0011;
    fpu_out_delay = 20;
    @(negedge clock);
    issue(2'd3, 4'b0011, 32'h40800000, 32'h40000000, 1);
    wait_state(2'd2, 20);
    do_reset();
    fpu_out_delay = 2;

    // After reset requester 0 wins over 3; division path for both.
    exp_q.push_back({1'b0, 2'd0, 32'h40000000});
    exp_q.push_back({1'b0, 2'd3, 32'h40000000});
    issue(2'd3, 4'b0011, 32'h40800000, 32'h40000000, 1);
    issue(2'd0, 4'b0011, 32'h40800000, 32'h40000000, 1);
    wait_resps(2, 100);

    // input_ack and output_rdy in the same cycle.
    cur_op = 4'b0000;
    fpu_out_delay = 0;
    exp_q.push_back({1'b0, 2'd2, 32'h3F8147AE});
    @(negedge clock);
    issue(2'd2, 4'b0000, 32'h3F800000, 32'h3C23D70A, 1);
    wait_resps(1, 60);
    fpu_out_delay = 2;
    check("pre_timeout_ack_pulses", 64'(ack_pulses), 64'd11);

    // fpu never produces a result.
    fpu_stall = 1'b1;
    @(negedge clock);
`ifdef FPU_ARB_TIMEOUT_EN
    exp_q.push_back({1'b1, 2'd1, 32'hFFFFFFFF});
    issue(2'd1, 4'b0000, 32'h3F800000, 32'h3C23D70A, 1);
    wait_resps(1, 60);
    check("timeout_ack_pulses", 64'(ack_pulses), 64'd12);
`else
    issue(2'd1, 4'b0000, 32'h3F800000, 32'h3C23D70A, 1);
    repeat (30) @(negedge clock);
    check("stuck_busy", 64'(busy), 64'd1);
    check("stuck_no_resp", 64'(bus.resp_valid), 64'd0);
    check("stuck_ack_pulses", 64'(ack_pulses), 64'd11);
`endif
    do_reset();
    fpu_stall = 1'b0;

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
